// File: rtl/mmio_lsu.sv
// Load/store unit with region decoder: one byte/half/word request at a time, lane strobes,
// replicated store data, formatted load data and misaligned/unmapped/timeout fault reporting.
module mmio_lsu #(
    parameter int unsigned                 NUM_REGIONS    = 2,
    parameter logic [NUM_REGIONS*32-1:0]   REGION_BASE    = {32'h32000, 32'h0},
    parameter logic [NUM_REGIONS*32-1:0]   REGION_SIZE    = {32'h10, 32'h32000},
    parameter int unsigned                 TIMEOUT_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic [1:0]                req_size_i,
    input  logic                      req_unsigned_i,
    input  logic [31:0]               req_addr_i,
    input  logic [31:0]               req_wdata_i,
    output logic                      rsp_valid_o,
    output logic [31:0]               rsp_rdata_o,
    output logic [1:0]                rsp_err_o,
    output logic [NUM_REGIONS-1:0]    slv_sel_o,
    output logic [3:0]                slv_we_o,
    output logic [31:0]               slv_addr_o,
    output logic [31:0]               slv_wdata_o,
    input  logic [NUM_REGIONS*32-1:0] slv_rdata_i,
    input  logic [NUM_REGIONS-1:0]    slv_ack_i
);

    localparam logic [1:0] ErrOk       = 2'd0;
    localparam logic [1:0] ErrAlign    = 2'd1;
    localparam logic [1:0] ErrUnmapped = 2'd2;
    localparam logic [1:0] ErrTimeout  = 2'd3;
    localparam logic [7:0] CntLast     = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e                 r_state;
    logic                   r_we;
    logic [1:0]             r_size;
    logic                   r_unsigned;
    logic [1:0]             r_off;
    logic [7:0]             r_cnt;
    logic                   r_rsp_valid;
    logic [31:0]            r_rsp_rdata;
    logic [1:0]             r_rsp_err;
    logic [NUM_REGIONS-1:0] r_sel;
    logic [3:0]             r_slv_we;
    logic [31:0]            r_slv_addr;
    logic [31:0]            r_slv_wdata;

    logic                   w_misaligned;
    logic                   w_hit;
    logic [NUM_REGIONS-1:0] w_sel;
    logic [31:0]            w_offset;
    logic [32:0]            w_lo;
    logic [32:0]            w_hi;
    logic [3:0]             w_strb;
    logic [31:0]            w_wdata;
    logic                   w_ack;
    logic [31:0]            w_rsel;
    logic [7:0]             w_byte;
    logic [15:0]            w_half;
    logic [31:0]            w_load;

    assign w_misaligned = (req_size_i == 2'd3) ||
                          (req_size_i == 2'd1 && req_addr_i[0]) ||
                          (req_size_i == 2'd2 && req_addr_i[1:0] != 2'b00);

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        w_hit    = 1'b0;
        w_sel    = '0;
        w_offset = '0;
        w_lo     = '0;
        w_hi     = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            w_lo = {1'b0, REGION_BASE[32*i +: 32]};
            w_hi = w_lo + {1'b0, REGION_SIZE[32*i +: 32]};
            if ({1'b0, req_addr_i} >= w_lo && {1'b0, req_addr_i} < w_hi) begin
                w_hit    = 1'b1;
                w_sel    = '0;
                w_sel[i] = 1'b1;
                w_offset = req_addr_i - REGION_BASE[32*i +: 32];
            end
        end
    end

    always_comb begin
        w_strb  = 4'b1111;
        w_wdata = req_wdata_i;
        case (req_size_i)
            2'd0: begin
                w_strb  = 4'b0001 << req_addr_i[1:0];
                w_wdata = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                w_strb  = req_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_rsel = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            w_rsel = w_rsel | (slv_rdata_i[32*i +: 32] & {32{r_sel[i]}});
        end
    end

    assign w_ack  = |(slv_ack_i & r_sel);
    assign w_byte = 8'(w_rsel >> {r_off, 3'b000});
    assign w_half = r_off[1] ? w_rsel[31:16] : w_rsel[15:0];

    always_comb begin
        w_load = w_rsel;
        case (r_size)
            2'd0:    w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'd1:    w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_we        <= 1'b0;
            r_size      <= 2'd0;
            r_unsigned  <= 1'b0;
            r_off       <= 2'd0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= ErrOk;
            r_sel       <= '0;
            r_slv_we    <= '0;
            r_slv_addr  <= '0;
            r_slv_wdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (req_valid_i) begin
                        r_we       <= req_we_i;
                        r_size     <= req_size_i;
                        r_unsigned <= req_unsigned_i;
                        r_off      <= req_addr_i[1:0];
                        r_cnt      <= '0;
                        if (w_misaligned) begin
                            r_state     <= StResp;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= ErrAlign;
                        end else if (!w_hit) begin
                            r_state     <= StResp;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= ErrUnmapped;
                        end else begin
                            r_state     <= StAccess;
                            r_sel       <= w_sel;
                            r_slv_addr  <= w_offset;
                            r_slv_we    <= req_we_i ? w_strb : 4'b0000;
                            r_slv_wdata <= w_wdata;
                        end
                    end
                end
                StAccess: begin
                    // Ack wins over timeout on the last permitted cycle.
                    if (w_ack || r_cnt == CntLast) begin
                        r_state     <= StResp;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= (w_ack && !r_we) ? w_load : 32'h0;
                        r_rsp_err   <= w_ack ? ErrOk : ErrTimeout;
                        r_sel       <= '0;
                        r_slv_we    <= '0;
                        r_slv_addr  <= '0;
                        r_slv_wdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                StResp:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready_o = (r_state == StIdle);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign slv_sel_o   = r_sel;
    assign slv_we_o    = r_slv_we;
    assign slv_addr_o  = r_slv_addr;
    assign slv_wdata_o = r_slv_wdata;

endmodule

// File: tb/tb_mmio_lsu.sv
// Directed bench for mmio_lsu: load formatting, store lanes, faults, wait states, timeout, reset.
module tb_mmio_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_err_o;
    logic [1:0]  slv_sel_o;
    logic [3:0]  slv_we_o;
    logic [31:0] slv_addr_o;
    logic [31:0] slv_wdata_o;
    logic [63:0] slv_rdata_i;
    logic [1:0]  slv_ack_i;

    int n_pass  = 0;
    int n_total = 0;
    int lat;
    int seen;

    mmio_lsu u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .slv_sel_o      (slv_sel_o),
        .slv_we_o       (slv_we_o),
        .slv_addr_o     (slv_addr_o),
        .slv_wdata_o    (slv_wdata_o),
        .slv_rdata_i    (slv_rdata_i),
        .slv_ack_i      (slv_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Presents a request for one cycle; returns at cycle N+1 with valid dropped.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        tick();
        req_valid_i    = 1'b0;
    endtask

    // Latency counted in cycles from accept; bounded by max_cyc.
    task automatic wait_rsp(input int max_cyc, output int l);
        l = 1;
        while (rsp_valid_o !== 1'b1 && l < max_cyc) begin
            tick();
            l++;
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0; req_unsigned_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0;
        slv_rdata_i = {32'h0, 32'h80FF_7F01};
        slv_ack_i = 2'b00;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        check("reset ready", 32'(req_ready_o), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("reset rdata", rsp_rdata_o, 32'h0);
        check("reset err", 32'(rsp_err_o), 32'd0);
        check("reset sel", 32'(slv_sel_o), 32'd0);
        check("reset we", 32'(slv_we_o), 32'd0);
        check("reset addr", slv_addr_o, 32'h0);
        check("reset wdata", slv_wdata_o, 32'h0);

        // lb at 0x3, zero-wait slave
        slv_ack_i = 2'b01;
        do_req(1'b0, 2'd0, 1'b0, 32'h3, 32'h0);
        check("lb ready low", 32'(req_ready_o), 32'd0);
        check("lb sel", 32'(slv_sel_o), 32'd1);
        wait_rsp(6, lat);
        check("lb latency", 32'(lat), 32'd2);
        check("lb rdata", rsp_rdata_o, 32'hFFFF_FF80);
        check("lb err", 32'(rsp_err_o), 32'd0);
        check("lb resp ready", 32'(req_ready_o), 32'd0);
        tick();
        check("lb pulse ends", 32'(rsp_valid_o), 32'd0);
        check("lb ready back", 32'(req_ready_o), 32'd1);

        do_req(1'b0, 2'd1, 1'b1, 32'h2, 32'h0);
        wait_rsp(6, lat);
        check("lhu rdata", rsp_rdata_o, 32'h0000_80FF);
        tick();
        do_req(1'b0, 2'd1, 1'b0, 32'h2, 32'h0);
        wait_rsp(6, lat);
        check("lh rdata", rsp_rdata_o, 32'hFFFF_80FF);
        tick();
        do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        wait_rsp(6, lat);
        check("lw rdata", rsp_rdata_o, 32'h80FF_7F01);
        tick();
        do_req(1'b0, 2'd0, 1'b1, 32'h1, 32'h0);
        wait_rsp(6, lat);
        check("lbu rdata", rsp_rdata_o, 32'h0000_007F);
        tick();

        // sb 0xA5 at 0x32001; ack on the unselected lane must be ignored
        slv_ack_i = 2'b00;
        do_req(1'b1, 2'd0, 1'b0, 32'h32001, 32'h0000_00A5);
        check("sb sel", 32'(slv_sel_o), 32'd2);
        check("sb addr", slv_addr_o, 32'h1);
        check("sb we", 32'(slv_we_o), 32'h2);
        check("sb wdata", slv_wdata_o, 32'hA5A5_A5A5);
        slv_ack_i = 2'b01;
        tick();
        check("sb foreign ack", 32'(rsp_valid_o), 32'd0);
        check("sb held we", 32'(slv_we_o), 32'h2);
        slv_ack_i = 2'b10;
        tick();
        check("sb rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("sb rdata", rsp_rdata_o, 32'h0);
        check("sb err", 32'(rsp_err_o), 32'd0);
        slv_ack_i = 2'b00;
        tick();

        do_req(1'b1, 2'd1, 1'b0, 32'h32002, 32'h1234_BEEF);
        check("sh addr", slv_addr_o, 32'h2);
        check("sh we", 32'(slv_we_o), 32'hC);
        check("sh wdata", slv_wdata_o, 32'hBEEF_BEEF);
        slv_ack_i = 2'b10;
        wait_rsp(6, lat);
        check("sh latency", 32'(lat), 32'd2);
        slv_ack_i = 2'b00;
        tick();

        // Faults respond at N+1 without selecting a slave
        do_req(1'b1, 2'd2, 1'b0, 32'h6, 32'hFFFF_FFFF);
        check("sw mis rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("sw mis err", 32'(rsp_err_o), 32'd1);
        check("sw mis sel", 32'(slv_sel_o), 32'd0);
        check("sw mis we", 32'(slv_we_o), 32'd0);
        tick();
        do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
        check("size3 rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("size3 err", 32'(rsp_err_o), 32'd1);
        tick();
        do_req(1'b0, 2'd2, 1'b0, 32'h32010, 32'h0);
        check("unmapped rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("unmapped err", 32'(rsp_err_o), 32'd2);
        check("unmapped rdata", rsp_rdata_o, 32'h0);
        tick();

        // Ack on exactly the 16th ACCESS cycle
        slv_rdata_i = {32'hDEAD_BEEF, 32'h80FF_7F01};
        do_req(1'b0, 2'd2, 1'b0, 32'h32004, 32'h0);
        check("wait addr", slv_addr_o, 32'h4);
        repeat (15) tick();
        check("wait no rsp yet", 32'(rsp_valid_o), 32'd0);
        slv_ack_i = 2'b10;
        tick();
        check("wait rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("wait err", 32'(rsp_err_o), 32'd0);
        check("wait rdata", rsp_rdata_o, 32'hDEAD_BEEF);
        slv_ack_i = 2'b00;
        tick();

        // No ack at all: timeout at N+17
        do_req(1'b0, 2'd2, 1'b0, 32'h32008, 32'h0);
        wait_rsp(40, lat);
        check("timeout latency", 32'(lat), 32'd17);
        check("timeout err", 32'(rsp_err_o), 32'd3);
        check("timeout rdata", rsp_rdata_o, 32'h0);
        tick();

        // Reset in the middle of a store access
        do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h1122_3344);
        check("rst pre sel", 32'(slv_sel_o), 32'd1);
        check("rst pre we", 32'(slv_we_o), 32'hF);
        #2 rst_ni = 1'b0;
        #1;
        check("rst async sel", 32'(slv_sel_o), 32'd0);
        check("rst async we", 32'(slv_we_o), 32'd0);
        seen = 0;
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid_o === 1'b1) seen++;
            tick();
        end
        check("rst no response", 32'(seen), 32'd0);
        check("rst ready", 32'(req_ready_o), 32'd1);

        slv_ack_i = 2'b01;
        do_req(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        wait_rsp(6, lat);
        check("post rst latency", 32'(lat), 32'd2);
        check("post rst rdata", rsp_rdata_o, 32'h0000_0001);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mmio_lsu.md
# mmio_lsu

Parametrised load/store unit and address decoder between the core's data port and N memory-mapped slaves (BRAM, GPIO, UART, timers). It accepts one byte, half-word or word request at a time over a valid/ready handshake, decodes it to one of `NUM_REGIONS` regions, and drives byte-lane strobes and replicated write data to the selected slave. It waits a variable number of cycles for the slave's acknowledge, then returns sign- or zero-extended load data with an error code. Misaligned, unmapped and timed-out accesses are reported as faults instead of being silently dropped.

## Interface
- `NUM_REGIONS`, 2, number of slave regions (1..16)
- `REGION_BASE`, {32'h32000, 32'h0}, flattened `NUM_REGIONS*32` base addresses; region i occupies bits [32*i+31:32*i]
- `REGION_SIZE`, {32'h10, 32'h32000}, flattened `NUM_REGIONS*32` region sizes in bytes; each size is nonzero
- `TIMEOUT_CYCLES`, 16, maximum number of ACCESS cycles to wait for an ack (1..255)

- `clk_i` in 1: the single clock
- `rst_ni` in 1: asynchronous, active-low reset
- `req_valid_i` in 1: request valid
- `req_ready_o` out 1: unit is idle and can accept a request
- `req_we_i` in 1: 1 = store, 0 = load
- `req_size_i` in 2: access size; 0 = byte, 1 = half-word, 2 = word, 3 = illegal
- `req_unsigned_i` in 1: zero-extend load data (lbu/lhu)
- `req_addr_i` in 32: byte address
- `req_wdata_i` in 32: store data, right-aligned
- `rsp_valid_o` out 1: single-cycle response pulse
- `rsp_rdata_o` out 32: formatted load data; 0 for stores and faults
- `rsp_err_o` out 2: 0 = OK, 1 = misaligned/illegal size, 2 = unmapped, 3 = timeout
- `slv_sel_o` out NUM_REGIONS: one-hot slave select, held for the whole access
- `slv_we_o` out 4: byte write strobes; 0 for loads
- `slv_addr_o` out 32: byte offset within the region (address minus base)
- `slv_wdata_o` out 32: lane-replicated write data
- `slv_rdata_i` in NUM_REGIONS*32: per-slave word read data
- `slv_ack_i` in NUM_REGIONS: per-slave acknowledge

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - `req_ready_o` = 1 only in IDLE.
  - A request is accepted when `req_valid_i` and `req_ready_o` are both 1. On accept, the unit registers we, size, unsigned, addr and wdata.
  - Illegal size, or misalignment (half-word with addr[0]=1; word with addr[1:0]≠0): go to RESP with err=1. No slave is selected.
  - No region matches: go to RESP with err=2.
  - Otherwise: go to ACCESS and clear the timeout counter.
- **Region match**
  - Region i matches when `BASE_i <= addr < BASE_i + SIZE_i`.
  - The upper bound is computed in 33 bits, so a region ending at 2^32 does not wrap.
  - When regions overlap, the lowest index wins.
- **ACCESS**
  - Drive `slv_sel_o` one-hot, `slv_addr_o`, `slv_we_o` and `slv_wdata_o`, all from the registered request and held stable.
  - When `slv_ack_i[sel]` = 1: capture the formatted `slv_rdata_i[sel]` and go to RESP with err=0.
  - Acks on unselected lanes are ignored.
  - The counter increments each ACCESS cycle without an ack. After TIMEOUT_CYCLES ack-less cycles, go to RESP with err=3.
  - An ack on the final permitted cycle counts as success: ack has priority over timeout.
- **RESP**
  - `rsp_valid_o` = 1 for exactly one cycle, then IDLE.
  - There is no response backpressure.
- **Store lanes**
  - Byte: `slv_we_o` = 1 << addr[1:0]; `slv_wdata_o` = the byte replicated ×4.
  - Half-word: `slv_we_o` = 4'b0011 when addr[1]=0, 4'b1100 when addr[1]=1; `slv_wdata_o` = the half-word replicated ×2.
  - Word: `slv_we_o` = 4'b1111.
- **Load format**
  - Byte: select lane addr[1:0]. Half-word: select half addr[1]. Word: pass through.
  - Sign-extend unless unsigned.
  - Stores return `rsp_rdata_o` = 0.

## Timing
- **Reset values:** state IDLE; `req_ready_o`=1 once reset is released. All other outputs are 0: `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o`, `slv_sel_o`, `slv_we_o`, `slv_addr_o`, `slv_wdata_o`.
- **Reset mid-access:** asserting `rst_ni` deasserts `slv_sel_o` and `slv_we_o` asynchronously, in the same cycle. No response is produced for the aborted request.
- **Response latency:**
  - Request accepted at cycle N: ACCESS starts at N+1.
  - Slave ack at cycle N+k (k ≥ 1): `rsp_valid_o` at N+k+1.
  - Zero-wait slave (ack in the first ACCESS cycle): response at N+2.
- **Fault latency:**
  - Misaligned or unmapped: response at N+1.
  - Timeout: response at N+TIMEOUT_CYCLES+1.
- **Throughput:** `req_ready_o` is 0 from N+1 through the RESP cycle. The next request can be accepted the cycle after RESP.
- **Output timing:** all outputs are registered or derived from the FSM state only; there is no combinational path from `req_*` to `slv_*`.

## Test plan
- **lb sign extension:** region 0 slave returns 32'h80FF_7F01 with ack=1; lb at 0x3 -> `rsp_rdata_o`=32'hFFFF_FF80, err=0, response 2 cycles after accept.
- **lhu zero extension:** same slave data; lhu at 0x2 -> `rsp_rdata_o`=32'h0000_80FF.
- **Store byte lanes:** sb 0xA5 at 0x32001 -> `slv_sel_o`=2'b10, `slv_addr_o`=1, `slv_we_o`=4'b0010, `slv_wdata_o`=32'hA5A5_A5A5.
- **Misaligned and illegal size:** sw at 0x6 -> err=1 at N+1 with `slv_sel_o` never asserted. size=3 -> err=1.
- **Unmapped address:** load at 0x32010 -> err=2 at N+1.
- **Wait states, timeout and reset:**
  - Ack delayed to exactly the 16th ACCESS cycle -> err=0.
  - No ack -> err=3 at N+17.
  - `rst_ni` pulsed low during ACCESS -> `slv_sel_o`=0 immediately; no `rsp_valid_o`; `req_ready_o`=1 after release.
